// File: rtl/pipeline_decode_queue.sv
// rtl/pipeline_decode_queue.sv - RV32/RV64 IM decode stage feeding a DEPTH-entry decoded-instruction queue
module pipeline_decode_queue #(
    parameter int          XLEN        = 64,
    parameter int          DEPTH       = 2,
    parameter logic [31:0] BUBBLE_WORD = 32'd90
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [3:0]                 out_ex_opcode,
    output logic [2:0]                 out_branch,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [XLEN-1:0]            out_imm,
    output logic                       out_imm_sel,
    output logic                       out_is_word,
    output logic [1:0]                 out_unsigned,
    output logic [2:0]                 out_mem_op,
    output logic [2:0]                 out_mem_size,
    output logic                       out_ecall,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit RV64  = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      ex_opcode;
        logic [2:0]      branch;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        logic            is_word;
        logic [1:0]      uns;
        logic [2:0]      mem_op;
        logic [2:0]      mem_size;
        logic            ecall;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, imm_shw;
    logic            shamt_ok, legal;
    entry_t          dec;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign imm_i   = XLEN'($signed(in_instr[31:20]));
    assign imm_s   = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b   = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_j   = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign imm_u   = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_sh  = RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
    assign imm_shw = XLEN'(in_instr[24:20]);
    // shamt[5] only exists on RV64
    assign shamt_ok = RV64 || !in_instr[25];

    always_comb begin
        dec    = '0;
        legal  = 1'b1;
        dec.pc = in_pc;
        case (opcode)
            7'h37: begin dec.ex_opcode = 4'd15; dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.imm_sel = 1'b1; dec.mem_op = 3'd3; end
            7'h17: begin dec.ex_opcode = 4'd14; dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.imm_sel = 1'b1; dec.mem_op = 3'd3; end
            7'h6F: begin
                dec.ex_opcode = 4'd13; dec.branch = 3'd6; dec.rd = in_instr[11:7];
                dec.imm = imm_j; dec.imm_sel = 1'b1; dec.mem_op = 3'd3;
            end
            7'h67: begin
                dec.ex_opcode = 4'd13; dec.branch = 3'd7; dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15];
                dec.imm = imm_i; dec.imm_sel = 1'b1; dec.mem_op = 3'd3;
                legal = (funct3 == 3'b000);
            end
            7'h63: begin
                dec.ex_opcode = 4'd2; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.imm = imm_b;
                case (funct3)
                    3'b000: dec.branch = 3'd0;
                    3'b001: dec.branch = 3'd1;
                    3'b100: dec.branch = 3'd2;
                    3'b101: dec.branch = 3'd3;
                    3'b110: begin dec.branch = 3'd2; dec.uns = 2'd1; end
                    3'b111: begin dec.branch = 3'd3; dec.uns = 2'd1; end
                    default: legal = 1'b0;
                endcase
            end
            7'h03: begin
                dec.ex_opcode = 4'd1; dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm = imm_i;
                dec.imm_sel = 1'b1; dec.mem_op = 3'd1; dec.mem_size = funct3;
                legal = (funct3 != 3'b111) && (RV64 || (funct3 != 3'b011 && funct3 != 3'b110));
            end
            7'h23: begin
                dec.ex_opcode = 4'd1; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.imm = imm_s;
                dec.imm_sel = 1'b1; dec.mem_op = 3'd2; dec.mem_size = funct3;
                legal = !funct3[2] && (RV64 || funct3 != 3'b011);
            end
            7'h13: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm = imm_i; dec.imm_sel = 1'b1; dec.mem_op = 3'd3;
                case (funct3)
                    3'b000: dec.ex_opcode = 4'd1;
                    3'b010: dec.ex_opcode = 4'd12;
                    3'b011: begin dec.ex_opcode = 4'd12; dec.uns = 2'd1; end
                    3'b100: dec.ex_opcode = 4'd5;
                    3'b110: dec.ex_opcode = 4'd3;
                    3'b111: dec.ex_opcode = 4'd4;
                    3'b001: begin
                        dec.ex_opcode = 4'd10; dec.imm = imm_sh;
                        legal = (in_instr[31:26] == 6'b000000) && shamt_ok;
                    end
                    default: begin
                        dec.ex_opcode = 4'd11; dec.imm = imm_sh; dec.uns = {1'b0, !in_instr[30]};
                        legal = (in_instr[31:26] == 6'b000000 || in_instr[31:26] == 6'b010000) && shamt_ok;
                    end
                endcase
            end
            7'h1B: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm_sel = 1'b1; dec.is_word = 1'b1; dec.mem_op = 3'd3;
                case (funct3)
                    3'b000: begin dec.ex_opcode = 4'd1; dec.imm = imm_i; legal = RV64; end
                    3'b001: begin dec.ex_opcode = 4'd10; dec.imm = imm_shw; legal = RV64 && funct7 == 7'h00; end
                    3'b101: begin
                        dec.ex_opcode = 4'd11; dec.imm = imm_shw; dec.uns = {1'b0, !in_instr[30]};
                        legal = RV64 && (funct7 == 7'h00 || funct7 == 7'h20);
                    end
                    default: legal = 1'b0;
                endcase
            end
            7'h33, 7'h3B: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
                dec.is_word = opcode[3]; dec.mem_op = 3'd3;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec.ex_opcode = 4'd1;
                    {7'h20, 3'b000}: dec.ex_opcode = 4'd2;
                    {7'h00, 3'b001}: dec.ex_opcode = 4'd10;
                    {7'h00, 3'b010}: dec.ex_opcode = 4'd12;
                    {7'h00, 3'b011}: begin dec.ex_opcode = 4'd12; dec.uns = 2'd1; end
                    {7'h00, 3'b100}: dec.ex_opcode = 4'd5;
                    {7'h00, 3'b101}: begin dec.ex_opcode = 4'd11; dec.uns = 2'd1; end
                    {7'h20, 3'b101}: dec.ex_opcode = 4'd11;
                    {7'h00, 3'b110}: dec.ex_opcode = 4'd3;
                    {7'h00, 3'b111}: dec.ex_opcode = 4'd4;
                    {7'h01, 3'b000}: dec.ex_opcode = 4'd6;
                    {7'h01, 3'b001}: dec.ex_opcode = 4'd7;
                    {7'h01, 3'b010}: begin dec.ex_opcode = 4'd7; dec.uns = 2'd2; end
                    {7'h01, 3'b011}: begin dec.ex_opcode = 4'd7; dec.uns = 2'd1; end
                    {7'h01, 3'b100}: dec.ex_opcode = 4'd8;
                    {7'h01, 3'b101}: begin dec.ex_opcode = 4'd8; dec.uns = 2'd1; end
                    {7'h01, 3'b110}: dec.ex_opcode = 4'd9;
                    {7'h01, 3'b111}: begin dec.ex_opcode = 4'd9; dec.uns = 2'd1; end
                    default: legal = 1'b0;
                endcase
                // *W forms exist only for add/sub/shifts and the non-MULH M ops
                if (opcode[3]) begin
                    if (!RV64 || funct3 == 3'b010 || funct3 == 3'b011) legal = 1'b0;
                    else if (funct7 == 7'h01 && funct3 == 3'b001) legal = 1'b0;
                    else if (funct7 != 7'h01 && funct3[2] && funct3 != 3'b101) legal = 1'b0;
                end
            end
            7'h73: begin dec.ecall = 1'b1; dec.mem_op = 3'd4; legal = (in_instr == 32'h0000_0073); end
            7'h0F: begin dec.mem_op = 3'd4; legal = (funct3[2:1] == 2'b00); end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    entry_t             head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q < CNT_W'(DEPTH)) || flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush && (in_instr != BUBBLE_WORD);
    assign pop       = out_valid && out_ready;
    assign occupancy = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_pc        = head.pc;
    assign out_ex_opcode = head.ex_opcode;
    assign out_branch    = head.branch;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_rd        = head.rd;
    assign out_imm       = head.imm;
    assign out_imm_sel   = head.imm_sel;
    assign out_is_word   = head.is_word;
    assign out_unsigned  = head.uns;
    assign out_mem_op    = head.mem_op;
    assign out_mem_size  = head.mem_size;
    assign out_ecall     = head.ecall;
    assign out_illegal   = head.illegal;
endmodule

// File: tb/tb_pipeline_decode_queue.sv
// tb/tb_pipeline_decode_queue.sv - scoreboard bench driving an RV64 and an RV32 instance in lockstep
module tb_pipeline_decode_queue;
    localparam logic [31:0] BUB = 32'd90;

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  ex;
        logic [2:0]  br;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm;
        logic        sel, w;
        logic [1:0]  uns;
        logic [2:0]  mop, msz;
        logic        ec, ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic a_in_ready, a_out_valid, a_imm_sel, a_is_word, a_ecall, a_illegal;
    logic [63:0] a_pc, a_imm;
    logic [3:0] a_ex; logic [2:0] a_br, a_mop, a_msz; logic [4:0] a_rs1, a_rs2, a_rd;
    logic [1:0] a_uns, a_occ;
    logic b_in_ready, b_out_valid, b_imm_sel, b_is_word, b_ecall, b_illegal;
    logic [31:0] b_pc, b_imm;
    logic [3:0] b_ex; logic [2:0] b_br, b_mop, b_msz; logic [4:0] b_rs1, b_rs2, b_rd;
    logic [1:0] b_uns, b_occ;

    int tests = 0;
    int fails = 0;
    exp_t q64[$];
    exp_t q32[$];

    always #5 clk = ~clk;

    pipeline_decode_queue #(.XLEN(64), .DEPTH(2), .BUBBLE_WORD(BUB)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_ex_opcode(a_ex), .out_branch(a_br), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
        .out_imm(a_imm), .out_imm_sel(a_imm_sel), .out_is_word(a_is_word), .out_unsigned(a_uns),
        .out_mem_op(a_mop), .out_mem_size(a_msz), .out_ecall(a_ecall), .out_illegal(a_illegal),
        .occupancy(a_occ));

    pipeline_decode_queue #(.XLEN(32), .DEPTH(2), .BUBBLE_WORD(BUB)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_pc(in_pc[31:0]), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_ex_opcode(b_ex), .out_branch(b_br), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_imm(b_imm), .out_imm_sel(b_imm_sel), .out_is_word(b_is_word), .out_unsigned(b_uns),
        .out_mem_op(b_mop), .out_mem_size(b_msz), .out_ecall(b_ecall), .out_illegal(b_illegal),
        .occupancy(b_occ));

    function automatic exp_t mk(input int pc, input int ex, input int br, input int rs1, input int rs2,
                                input int rd, input longint imm, input int sel, input int w, input int uns,
                                input int mop, input int msz, input int ec);
        exp_t e;
        e.pc = 64'(pc); e.ex = 4'(ex); e.br = 3'(br); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.rd = 5'(rd);
        e.imm = 64'(imm); e.sel = 1'(sel); e.w = 1'(w); e.uns = 2'(uns); e.mop = 3'(mop); e.msz = 3'(msz);
        e.ec = 1'(ec); e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t ill(input int pc);
        exp_t e;
        e = '0;
        e.pc = 64'(pc);
        e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t trunc(input exp_t e);
        exp_t t;
        t = e;
        t.pc[63:32] = 32'h0;
        t.imm[63:32] = 32'h0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_entry(input string name, input exp_t act, input exp_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s pc=%h: got %h expected %h", name, exp.pc, act, exp);
        end
    endtask

    // Scoreboard monitor: each instance pops its own expectation when it hands off a head entry
    always @(negedge clk) begin
        exp_t act, e;
        if (a_out_valid === 1'b1 && out_ready === 1'b1) begin
            act = {a_pc, a_ex, a_br, a_rs1, a_rs2, a_rd, a_imm, a_imm_sel, a_is_word, a_uns, a_mop, a_msz, a_ecall, a_illegal};
            if (q64.size() == 0) begin
                tests++; fails++;
                $display("FAIL xlen64 unexpected output: got %h expected none", act);
            end else begin
                e = q64.pop_front();
                chk_entry("xlen64 entry", act, e);
            end
        end
        if (b_out_valid === 1'b1 && out_ready === 1'b1) begin
            act = {32'h0, b_pc, b_ex, b_br, b_rs1, b_rs2, b_rd, 32'h0, b_imm, b_imm_sel, b_is_word, b_uns, b_mop, b_msz, b_ecall, b_illegal};
            if (q32.size() == 0) begin
                tests++; fails++;
                $display("FAIL xlen32 unexpected output: got %h expected none", act);
            end else begin
                e = q32.pop_front();
                chk_entry("xlen32 entry", act, e);
            end
        end
    end

    task automatic push(input logic [31:0] instr, input exp_t e64, input exp_t e32);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = e64.pc;
        q64.push_back(e64);
        q32.push_back(trunc(e32));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_raw(input logic [31:0] instr, input int pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = 64'(pc);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, " occ64"}, 64'(a_occ), 64'd0);
        chk({name, " occ32"}, 64'(b_occ), 64'd0);
        chk({name, " valid64"}, 64'(a_out_valid), 64'd0);
        chk({name, " fields64"}, {a_pc[31:0], a_imm[15:0], a_ex, a_rd, a_mop, a_illegal, a_ecall, a_rs1}, 64'd0);
        chk({name, " fields32"}, {b_pc, b_imm[15:0], b_ex, b_rd, b_mop, b_illegal, b_ecall, b_rs1}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = 32'h0; in_pc = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset in_ready64", 64'(a_in_ready), 64'd1);
        reset = 1'b0;
        out_ready = 1'b1;

        e = mk('h100, 1, 0, 0, 0, 1, 5, 1, 0, 0, 3, 0, 0);
        push(32'h00500093, e, e);
        chk("latency out_valid64", 64'(a_out_valid), 64'd1);
        chk("latency out_valid32", 64'(b_out_valid), 64'd1);

        e = mk('h104, 2, 1, 1, 2, 0, -4, 0, 0, 0, 0, 0, 0);          push(32'hFE209EE3, e, e);
        e = mk('h108, 6, 0, 1, 2, 3, 0, 0, 0, 0, 3, 0, 0);           push(32'h022081B3, e, e);
        e = mk('h10C, 2, 0, 6, 7, 5, 0, 0, 0, 0, 3, 0, 0);           push(32'h407302B3, e, e);
        e = mk('h110, 7, 0, 2, 3, 1, 0, 0, 0, 2, 3, 0, 0);           push(32'h023120B3, e, e);
        e = mk('h114, 1, 0, 2, 0, 4, -8, 1, 0, 0, 1, 2, 0);          push(32'hFF812203, e, e);
        e = mk('h118, 1, 0, 1, 5, 0, 12, 1, 0, 0, 2, 2, 0);          push(32'h0050A623, e, e);
        e = mk('h11C, 15, 0, 0, 0, 7, -64'sh80000000, 1, 0, 0, 3, 0, 0); push(32'h800003B7, e, e);
        e = mk('h120, 13, 6, 0, 0, 1, 8, 1, 0, 0, 3, 0, 0);          push(32'h008000EF, e, e);
        e = mk('h124, 11, 0, 2, 0, 1, 3, 1, 0, 0, 3, 0, 0);          push(32'h40315093, e, e);
        e = mk('h128, 2, 2, 1, 2, 0, 8, 0, 0, 1, 0, 0, 0);           push(32'h0020E463, e, e);
        e = mk('h12C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1);           push(32'h00000073, e, e);
        e = mk('h130, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);           push(32'h0000000F, e, e);
        push(32'hFFFFFFFF, ill('h134), ill('h134));
        push(32'h0010809B, mk('h138, 1, 0, 1, 0, 1, 1, 1, 1, 0, 3, 0, 0), ill('h138));
        push(32'h00013203, mk('h13C, 1, 0, 2, 0, 4, 0, 1, 0, 0, 1, 3, 0), ill('h13C));
        push(32'h02111093, mk('h140, 10, 0, 2, 0, 1, 33, 1, 0, 0, 3, 0, 0), ill('h140));
        @(posedge clk); #1;

        // Backpressure: fill to DEPTH, refused push, then ordered drain
        out_ready = 1'b0;
        e = mk('h200, 1, 0, 0, 0, 1, 5, 1, 0, 0, 3, 0, 0);           push(32'h00500093, e, e);
        e = mk('h204, 6, 0, 1, 2, 3, 0, 0, 0, 0, 3, 0, 0);           push(32'h022081B3, e, e);
        chk("full occ64", 64'(a_occ), 64'd2);
        chk("full occ32", 64'(b_occ), 64'd2);
        chk("full in_ready64", 64'(a_in_ready), 64'd0);
        chk("full in_ready32", 64'(b_in_ready), 64'd0);
        drive_raw(32'h407302B3, 'h208);
        chk("refused push occ64", 64'(a_occ), 64'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain1 occ64", 64'(a_occ), 64'd1);
        @(posedge clk); #1;
        chk("drain2 occ64", 64'(a_occ), 64'd0);
        chk("drain2 valid64", 64'(a_out_valid), 64'd0);

        // Flush with a same-cycle push that must be lost
        out_ready = 1'b0;
        e = mk('h300, 1, 0, 0, 0, 1, 5, 1, 0, 0, 3, 0, 0);           push(32'h00500093, e, e);
        e = mk('h304, 6, 0, 1, 2, 3, 0, 0, 0, 0, 3, 0, 0);           push(32'h022081B3, e, e);
        flush = 1'b1;
        #1;
        chk("flush in_ready64", 64'(a_in_ready), 64'd1);
        drive_raw(32'h407302B3, 'h308);
        flush = 1'b0;
        q64.delete();
        q32.delete();
        chk_idle("after flush");
        out_ready = 1'b1;
        e = mk('h30C, 12, 0, 0, 0, 1, 5, 1, 0, 0, 3, 0, 0);          push(32'h00502093, e, e);
        @(posedge clk); #1;

        // Bubble stream interleaved with real pushes, then reset mid-stream
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                e = mk('h400 + 4 * i, 1, 0, 0, 0, 1, 5, 1, 0, 0, 3, 0, 0);
                push(32'h00500093, e, e);
            end else begin
                drive_raw(BUB, 'h400 + 4 * i);
                chk("bubble occ64", 64'(a_occ), 64'd0);
                chk("bubble occ32", 64'(b_occ), 64'd0);
            end
        end
        out_ready = 1'b0;
        reset = 1'b1;
        q64.delete();
        q32.delete();
        drive_raw(32'h00500093, 'h500);
        reset = 1'b0;
        chk_idle("mid-stream reset");

        out_ready = 1'b1;
        e = mk('h600, 1, 0, 0, 0, 1, 5, 1, 0, 0, 3, 0, 0);           push(32'h00500093, e, e);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained64", 64'(q64.size()), 64'd0);
        chk("scoreboard drained32", 64'(q32.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
